// File: rtl/multicore_pkg.sv
// Shared types and constants for the core pipeline: load/store opcodes,
// MA-stage FSM states and write-back source selection.
package multicore_pkg;

    localparam int DATA_SIZE = 32;
    localparam int INST_SIZE = 32;
    localparam int NUM_REGS  = 32;
    localparam int REG_W     = $clog2(NUM_REGS);

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LBU = 3'd3,
        LHU = 3'd4
    } t_ldop;

    typedef enum logic [1:0] {
        SB = 2'd0,
        SH = 2'd1,
        SW = 2'd2
    } t_sop;

    typedef enum logic {
        MA_IDLE = 1'b0,
        MA_WAIT = 1'b1
    } t_ma_state;

    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MEM = 2'b01;
    localparam logic [1:0] MTR_PC  = 2'b10;

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane steering for the data port: store replication,
// byte enables, load extraction/extension and alignment checking.
module load_store_align
    import multicore_pkg::*;
(
    input  logic [1:0]           addr_lo,
    input  logic                 is_store,
    input  t_ldop                ldop,
    input  t_sop                 sop,
    input  logic [DATA_SIZE-1:0] store_data,
    input  logic [DATA_SIZE-1:0] rdata,
    output logic [DATA_SIZE-1:0] wdata,
    output logic [3:0]           be,
    output logic [DATA_SIZE-1:0] load_data,
    output logic                 misaligned
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Each lane carries the low byte (SB), the matching half-word byte (SH)
    // or its own byte (SW), so the memory only needs to honour be.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wdata[gi*8 +: 8] =
                (is_store && sop == SB) ? store_data[7:0] :
                (is_store && sop == SH) ? store_data[(gi%2)*8 +: 8] :
                                          store_data[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        be         = 4'b1111;
        misaligned = 1'b0;
        if (is_store) begin
            case (sop)
                SB:      be = 4'b0001 << addr_lo;
                SH: begin
                    be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                    misaligned = addr_lo[0];
                end
                SW:      misaligned = |addr_lo;
                default: be = 4'b1111;
            endcase
        end else begin
            case (ldop)
                LH, LHU: misaligned = addr_lo[0];
                LW:      misaligned = |addr_lo;
                default: misaligned = 1'b0;
            endcase
        end
    end

    assign ld_byte = rdata[{addr_lo, 3'b000} +: 8];
    assign ld_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        load_data = rdata;
        case (ldop)
            LB:      load_data = {{24{ld_byte[7]}}, ld_byte};
            LBU:     load_data = {24'd0, ld_byte};
            LH:      load_data = {{16{ld_half[15]}}, ld_half};
            LHU:     load_data = {16'd0, ld_half};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/memory_access_unit.sv
// Memory-access pipeline stage: MA register, valid/ack data-port FSM with
// ack timeout, pipeline stall generation and the WB output register.
module memory_access_unit
    import multicore_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
)(
    input  logic                 i_aclk,
    input  logic                 i_areset_n,
    input  logic                 i_en,
    input  logic [DATA_SIZE-1:0] i_exe_calc,
    input  logic [DATA_SIZE-1:0] i_exe_wdata,
    input  logic [INST_SIZE-1:0] i_pcplus4,
    input  logic [REG_W-1:0]     i_rdest,
    input  logic                 i_cu_regwrite,
    input  logic                 i_cu_memwrite,
    input  logic                 i_cu_memaccess,
    input  logic [1:0]           i_cu_memtoreg,
    input  t_ldop                i_ldop,
    input  t_sop                 i_sop,
    output logic                 o_dmem_req,
    output logic                 o_dmem_we,
    output logic [DATA_SIZE-1:0] o_dmem_addr,
    output logic [DATA_SIZE-1:0] o_dmem_wdata,
    output logic [3:0]           o_dmem_be,
    input  logic                 i_dmem_ack,
    input  logic [DATA_SIZE-1:0] i_dmem_rdata,
    output logic                 o_stall,
    output logic [DATA_SIZE-1:0] o_ma_op,
    output logic [DATA_SIZE-1:0] o_wb_data,
    output logic [REG_W-1:0]     o_rdest,
    output logic                 o_cu_regwrite,
    output logic                 o_misaligned,
    output logic                 o_bus_err
);

    localparam logic [15:0] CNT_LOAD = 16'(ACK_TIMEOUT - 1);

    logic                 ma_valid_reg;
    logic [DATA_SIZE-1:0] calc_reg;
    logic [DATA_SIZE-1:0] wdata_reg;
    logic [INST_SIZE-1:0] pcplus4_reg;
    logic [REG_W-1:0]     rdest_reg;
    logic                 regwrite_reg;
    logic                 memwrite_reg;
    logic                 memaccess_reg;
    logic [1:0]           memtoreg_reg;
    t_ldop                ldop_reg;
    t_sop                 sop_reg;

    t_ma_state            state_reg, state_next;
    logic [15:0]          cnt_reg, cnt_next;

    logic                 misal_raw;
    logic                 misaligned;
    logic                 mem_op;
    logic                 last_cycle;
    logic                 timeout_expire;
    logic [DATA_SIZE-1:0] lane_wdata;
    logic [DATA_SIZE-1:0] load_data;
    logic [3:0]           lane_be;
    logic [DATA_SIZE-1:0] wb_mux;

    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            ma_valid_reg  <= 1'b0;
            calc_reg      <= '0;
            wdata_reg     <= '0;
            pcplus4_reg   <= '0;
            rdest_reg     <= '0;
            regwrite_reg  <= 1'b0;
            memwrite_reg  <= 1'b0;
            memaccess_reg <= 1'b0;
            memtoreg_reg  <= MTR_ALU;
            ldop_reg      <= LB;
            sop_reg       <= SB;
        end else if (!o_stall) begin
            ma_valid_reg  <= i_en;
            calc_reg      <= i_exe_calc;
            wdata_reg     <= i_exe_wdata;
            pcplus4_reg   <= i_pcplus4;
            rdest_reg     <= i_rdest;
            regwrite_reg  <= i_cu_regwrite;
            memwrite_reg  <= i_cu_memwrite;
            memaccess_reg <= i_cu_memaccess;
            memtoreg_reg  <= i_cu_memtoreg;
            ldop_reg      <= i_ldop;
            sop_reg       <= i_sop;
        end
    end

    load_store_align u_align (
        .addr_lo    (calc_reg[1:0]),
        .is_store   (memwrite_reg),
        .ldop       (ldop_reg),
        .sop        (sop_reg),
        .store_data (wdata_reg),
        .rdata      (i_dmem_rdata),
        .wdata      (lane_wdata),
        .be         (lane_be),
        .load_data  (load_data),
        .misaligned (misal_raw)
    );

    assign misaligned = memaccess_reg & misal_raw;
    assign mem_op     = ma_valid_reg & memaccess_reg & ~misal_raw;

    // The request cycle in IDLE is the first of ACK_TIMEOUT cycles, so the
    // last permitted cycle is WAIT with one count left (or IDLE itself when
    // the timeout is a single cycle).
    assign last_cycle     = (state_reg == MA_IDLE) ? (ACK_TIMEOUT == 1) : (cnt_reg == 16'd1);
    assign timeout_expire = mem_op & ~i_dmem_ack & last_cycle;
    assign o_stall        = mem_op & ~i_dmem_ack & ~timeout_expire;

    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state_reg <= MA_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            MA_IDLE: begin
                if (mem_op && !i_dmem_ack && !timeout_expire) begin
                    state_next = MA_WAIT;
                    cnt_next   = CNT_LOAD;
                end
            end
            MA_WAIT: begin
                if (i_dmem_ack || timeout_expire) begin
                    state_next = MA_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - 16'd1;
                end
            end
            default: begin
                state_next = MA_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign o_dmem_req   = mem_op;
    assign o_dmem_we    = mem_op & memwrite_reg;
    assign o_dmem_addr  = {calc_reg[DATA_SIZE-1:2], 2'b00};
    assign o_dmem_wdata = lane_wdata;
    assign o_dmem_be    = mem_op ? lane_be : 4'b0000;

    assign o_ma_op = (memtoreg_reg == MTR_PC) ? pcplus4_reg : calc_reg;

    always_comb begin
        case (memtoreg_reg)
            MTR_MEM: wb_mux = load_data;
            MTR_PC:  wb_mux = pcplus4_reg;
            default: wb_mux = calc_reg;
        endcase
    end

    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            o_cu_regwrite <= 1'b0;
            o_rdest       <= '0;
            o_wb_data     <= '0;
            o_misaligned  <= 1'b0;
            o_bus_err     <= 1'b0;
        end else begin
            o_misaligned <= ma_valid_reg & misaligned;
            o_bus_err    <= timeout_expire;
            if (o_stall) begin
                o_cu_regwrite <= 1'b0;
            end else begin
                o_cu_regwrite <= ma_valid_reg & regwrite_reg & ~misaligned & ~timeout_expire;
                o_rdest       <= rdest_reg;
                o_wb_data     <= wb_mux;
            end
        end
    end

endmodule

// File: tb/tb_memory_access_unit.sv
// Self-checking bench for memory_access_unit: directed cases plus random
// instructions scored against a transaction-level reference model.
module tb_memory_access_unit;
    import multicore_pkg::*;

    localparam int T = 4;

    logic                 i_aclk = 1'b0;
    logic                 i_areset_n = 1'b0;
    logic                 i_en = 1'b0;
    logic [DATA_SIZE-1:0] i_exe_calc = '0;
    logic [DATA_SIZE-1:0] i_exe_wdata = '0;
    logic [INST_SIZE-1:0] i_pcplus4 = '0;
    logic [REG_W-1:0]     i_rdest = '0;
    logic                 i_cu_regwrite = 1'b0;
    logic                 i_cu_memwrite = 1'b0;
    logic                 i_cu_memaccess = 1'b0;
    logic [1:0]           i_cu_memtoreg = 2'b00;
    t_ldop                i_ldop = LB;
    t_sop                 i_sop = SB;
    logic                 o_dmem_req;
    logic                 o_dmem_we;
    logic [DATA_SIZE-1:0] o_dmem_addr;
    logic [DATA_SIZE-1:0] o_dmem_wdata;
    logic [3:0]           o_dmem_be;
    logic                 i_dmem_ack = 1'b0;
    logic [DATA_SIZE-1:0] i_dmem_rdata = '0;
    logic                 o_stall;
    logic [DATA_SIZE-1:0] o_ma_op;
    logic [DATA_SIZE-1:0] o_wb_data;
    logic [REG_W-1:0]     o_rdest;
    logic                 o_cu_regwrite;
    logic                 o_misaligned;
    logic                 o_bus_err;

    int total = 0;
    int bad   = 0;
    int txn   = 0;

    memory_access_unit #(.ACK_TIMEOUT(T)) dut (
        .i_aclk         (i_aclk),
        .i_areset_n     (i_areset_n),
        .i_en           (i_en),
        .i_exe_calc     (i_exe_calc),
        .i_exe_wdata    (i_exe_wdata),
        .i_pcplus4      (i_pcplus4),
        .i_rdest        (i_rdest),
        .i_cu_regwrite  (i_cu_regwrite),
        .i_cu_memwrite  (i_cu_memwrite),
        .i_cu_memaccess (i_cu_memaccess),
        .i_cu_memtoreg  (i_cu_memtoreg),
        .i_ldop         (i_ldop),
        .i_sop          (i_sop),
        .o_dmem_req     (o_dmem_req),
        .o_dmem_we      (o_dmem_we),
        .o_dmem_addr    (o_dmem_addr),
        .o_dmem_wdata   (o_dmem_wdata),
        .o_dmem_be      (o_dmem_be),
        .i_dmem_ack     (i_dmem_ack),
        .i_dmem_rdata   (i_dmem_rdata),
        .o_stall        (o_stall),
        .o_ma_op        (o_ma_op),
        .o_wb_data      (o_wb_data),
        .o_rdest        (o_rdest),
        .o_cu_regwrite  (o_cu_regwrite),
        .o_misaligned   (o_misaligned),
        .o_bus_err      (o_bus_err)
    );

    always #5 i_aclk = ~i_aclk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, obs, exp);
        end
    endtask

    // One instruction through MA/WB; d = ack delay in cycles (d >= T: never acked).
    task automatic run_instr(input logic [31:0] calc, input logic [31:0] sdata,
                             input logic [31:0] pc4, input logic [REG_W-1:0] rd,
                             input logic rw, input logic mw, input logic ma,
                             input logic [1:0] mtr, input t_ldop lo, input t_sop so,
                             input int d, input logic [31:0] rdata);
        logic [1:0]  a;
        logic        mis, memop, never, berr, rw_exp, done;
        logic [3:0]  be_exp;
        logic [31:0] wd_exp, b, h, ld, wb_exp;
        int          req_exp, stall_exp, req_n, stall_n, cyc;

        a      = calc[1:0];
        mis    = ma && (mw ? ((so == SH && a[0]) || (so == SW && a != 2'b00))
                           : (((lo == LH || lo == LHU) && a[0]) || (lo == LW && a != 2'b00)));
        memop  = ma && !mis;
        never  = (d >= T);
        berr   = memop && never;
        rw_exp = rw && !mis && !berr;
        req_exp   = !memop ? 0 : (berr ? T : d + 1);
        stall_exp = !memop ? 0 : (berr ? T - 1 : d);

        be_exp = 4'hF;
        wd_exp = sdata;
        if (mw && so == SB) begin
            be_exp = 4'(1 << a);
            wd_exp = (sdata & 32'hFF) * 32'h0101_0101;
        end else if (mw && so == SH) begin
            be_exp = a[1] ? 4'hC : 4'h3;
            wd_exp = (sdata & 32'hFFFF) * 32'h0001_0001;
        end

        b = (rdata >> (8 * a)) & 32'hFF;
        h = (rdata >> (16 * a[1])) & 32'hFFFF;
        case (lo)
            LB:      ld = (b >= 128) ? b + 32'hFFFF_FF00 : b;
            LBU:     ld = b;
            LH:      ld = (h >= 32768) ? h + 32'hFFFF_0000 : h;
            LHU:     ld = h;
            default: ld = rdata;
        endcase
        wb_exp = (mtr == 2'b01) ? ld : (mtr == 2'b10) ? pc4 : calc;

        @(negedge i_aclk);
        i_exe_calc = calc; i_exe_wdata = sdata; i_pcplus4 = pc4; i_rdest = rd;
        i_cu_regwrite = rw; i_cu_memwrite = mw; i_cu_memaccess = ma;
        i_cu_memtoreg = mtr; i_ldop = lo; i_sop = so;
        i_dmem_rdata = rdata; i_dmem_ack = 1'b0; i_en = 1'b1;
        @(posedge i_aclk);
        @(negedge i_aclk);
        i_en = 1'b0;

        cyc = 0; req_n = 0; stall_n = 0; done = 1'b0;
        while (!done) begin
            i_dmem_ack = memop && !never && (cyc == d);
            #1;
            if (cyc == 0) begin
                check_val("ma_op", o_ma_op, (mtr == 2'b10) ? pc4 : calc);
                check_val("pulse_idle", {30'd0, o_misaligned, o_bus_err}, 32'd0);
            end
            check_val("wb_bubble", o_cu_regwrite, 1'b0);
            if (o_dmem_req) begin
                req_n++;
                check_val("we", o_dmem_we, mw);
                check_val("addr", o_dmem_addr, {calc[31:2], 2'b00});
                check_val("be", o_dmem_be, be_exp);
                if (mw) check_val("wdata", o_dmem_wdata, wd_exp);
            end
            if (o_stall) stall_n++;
            else done = 1'b1;
            if (!done) begin
                cyc++;
                if (cyc > 20) begin
                    check_val("stall_bound", o_stall, 1'b0);
                    done = 1'b1;
                end else begin
                    @(negedge i_aclk);
                end
            end
        end
        check_val("req_cycles", req_n, req_exp);
        check_val("stall_cycles", stall_n, stall_exp);

        @(posedge i_aclk);
        @(negedge i_aclk);
        i_dmem_ack = 1'b0;
        #1;
        check_val("regwrite", o_cu_regwrite, rw_exp);
        if (rw_exp) begin
            check_val("rdest", o_rdest, rd);
            check_val("wb_data", o_wb_data, wb_exp);
        end
        check_val("misaligned", o_misaligned, mis);
        check_val("bus_err", o_bus_err, berr);
        check_val("req_after", o_dmem_req, 1'b0);
        $display("txn %0d: calc=%08h mem=%0b we=%0b mtr=%0d d=%0d wb=%08h rw=%0b mis=%0b berr=%0b",
                 txn, calc, ma, mw, mtr, d, o_wb_data, o_cu_regwrite, o_misaligned, o_bus_err);
        txn++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_req"}, {o_dmem_req, o_dmem_we, o_stall}, 3'b000);
        check_val({tag, "_rw"}, {o_cu_regwrite, o_misaligned, o_bus_err}, 3'b000);
        check_val({tag, "_wb"}, o_wb_data, 32'd0);
        check_val({tag, "_rd"}, o_rdest, '0);
        check_val({tag, "_be"}, o_dmem_be, 4'd0);
    endtask

    initial begin
        logic        r_ma, r_mw;
        logic [1:0]  r_mtr;
        int          r_sel, r_d;

        @(negedge i_aclk);
        @(negedge i_aclk);
        #1;
        check_reset_outputs("reset");
        @(negedge i_aclk);
        i_areset_n = 1'b1;

        run_instr(32'h1234, 32'h0, 32'h40, 5'd5, 1'b1, 1'b0, 1'b0, 2'b00, LB, SB, 0, 32'h0);
        run_instr(32'h103, 32'hAB, 32'h44, 5'd3, 1'b0, 1'b1, 1'b1, 2'b00, LB, SB, 0, 32'h0);
        run_instr(32'h102, 32'h0, 32'h48, 5'd7, 1'b1, 1'b0, 1'b1, 2'b01, LB, SB, 3, 32'h0080_0000);
        run_instr(32'h102, 32'h0, 32'h4C, 5'd8, 1'b1, 1'b0, 1'b1, 2'b01, LBU, SB, 3, 32'h0080_0000);
        run_instr(32'h102, 32'h5566_7788, 32'h50, 5'd9, 1'b1, 1'b1, 1'b1, 2'b00, LB, SW, 0, 32'h0);
        run_instr(32'h77, 32'h0, 32'h54, 5'd10, 1'b1, 1'b0, 1'b0, 2'b00, LB, SB, 0, 32'h0);
        run_instr(32'h200, 32'h0, 32'h58, 5'd11, 1'b1, 1'b0, 1'b1, 2'b01, LW, SB, 99, 32'hDEAD_BEEF);
        run_instr(32'h206, 32'h0, 32'h5C, 5'd12, 1'b1, 1'b0, 1'b1, 2'b01, LH, SB, T - 1, 32'h8123_4567);
        run_instr(32'h300, 32'h0, 32'h60, 5'd1, 1'b1, 1'b0, 1'b0, 2'b10, LB, SB, 0, 32'h0);
        run_instr(32'h302, 32'hBEEF, 32'h64, 5'd2, 1'b1, 1'b1, 1'b1, 2'b00, LB, SH, 1, 32'h0);

        // Reset while a load is parked in WAIT.
        @(negedge i_aclk);
        i_exe_calc = 32'h400; i_cu_memaccess = 1'b1; i_cu_memwrite = 1'b0;
        i_cu_regwrite = 1'b1; i_cu_memtoreg = 2'b01; i_ldop = LW; i_en = 1'b1;
        i_dmem_ack = 1'b0;
        @(posedge i_aclk);
        @(negedge i_aclk);
        i_en = 1'b0;
        @(negedge i_aclk);
        #1;
        check_val("wait_req", {o_dmem_req, o_stall}, 2'b11);
        #1;
        i_areset_n = 1'b0;
        #1;
        check_val("rst_async_req", {o_dmem_req, o_stall}, 2'b00);
        @(negedge i_aclk);
        i_areset_n = 1'b1;
        #1;
        check_reset_outputs("rst_wait");
        run_instr(32'h404, 32'h0, 32'h68, 5'd4, 1'b1, 1'b0, 1'b1, 2'b01, LW, SB, 0, 32'hCAFE_F00D);

        for (int i = 0; i < 40; i++) begin
            r_ma = ($urandom_range(0, 2) != 0);
            r_mw = r_ma && ($urandom_range(0, 1) == 1);
            r_sel = $urandom_range(0, 2);
            if (r_ma && !r_mw) r_mtr = 2'b01;
            else r_mtr = (r_sel == 0) ? 2'b00 : (r_sel == 1) ? 2'b10 : 2'b11;
            r_d = $urandom_range(0, 5);
            run_instr($urandom, $urandom, $urandom, REG_W'($urandom_range(0, NUM_REGS - 1)),
                      1'($urandom_range(0, 1)), r_mw, r_ma, r_mtr,
                      t_ldop'($urandom_range(0, 4)), t_sop'($urandom_range(0, 2)),
                      r_d, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_access_unit.md
# memory_access_unit

Memory-access (MA) pipeline stage directly downstream of the execute stage. It registers the execute results and control, and runs load/store transactions on a valid/ack data-memory port. It also does byte-lane steering, load sign/zero extension and misalignment detection. It stalls the pipeline while a transaction is outstanding, feeds the MA forwarding operand back to execute, and delivers write-back data, destination and regwrite to the WB stage.

## Interface
- ACK_TIMEOUT, 255: max cycles waiting for i_dmem_ack before bus error (1..65535)
- i_aclk  in  1  clock
- i_areset_n  in  1  reset i_areset_n, asynchronous, active-low; clock i_aclk
- i_en  in  1  incoming execute instruction valid; low inserts bubble
- i_exe_calc  in  DATA_SIZE  ALU/system result; memory byte address for loads/stores
- i_exe_wdata  in  DATA_SIZE  store data (unaligned, LSB-justified)
- i_pcplus4  in  INST_SIZE  link value for JAL/JALR
- i_rdest  in  $clog2(NUM_REGS)  write-back register
- i_cu_regwrite, i_cu_memwrite, i_cu_memaccess  in  1 each  pipelined control
- i_cu_memtoreg  in  2  00 ALU, 01 memory, 10 pcplus4, 11 reserved (treated as 00)
- i_ldop  in  t_ldop  load size/sign
- i_sop  in  t_sop  store size
- o_dmem_req  out  1  transaction request
- o_dmem_we  out  1  1 store, 0 load
- o_dmem_addr  out  DATA_SIZE  word address {calc[31:2],2'b00}
- o_dmem_wdata  out  DATA_SIZE  lane-replicated store data
- o_dmem_be  out  4  byte enables
- i_dmem_ack  in  1  transaction complete; rdata valid same cycle
- i_dmem_rdata  in  DATA_SIZE  read word
- o_stall  out  1  freeze IF/ID/EX; MA holds
- o_ma_op  out  DATA_SIZE  forward operand to execute
- o_wb_data  out  DATA_SIZE  write-back value
- o_rdest  out  $clog2(NUM_REGS)  write-back register
- o_cu_regwrite  out  1  write-back enable
- o_misaligned  out  1  one-cycle pulse, misaligned access dropped
- o_bus_err  out  1  one-cycle pulse, ack timeout

## Operation
- MA register captures all inputs when o_stall=0; ma_valid<=i_en. When o_stall=1 it holds.
- mem_op = ma_valid & memaccess & ~misaligned.
- Misaligned when: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - No request is issued and o_misaligned pulses.
  - The instruction retires with regwrite forced 0.
- Store lanes:
  - SB: be=1<<addr[1:0], wdata={4{byte}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata={2{half}}.
  - SW: be=1111.
  - Loads drive be=1111 and we=0.
- Load extract: byte at lane addr[1:0] or half at addr[1]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- FSM IDLE/WAIT:
  - IDLE: o_dmem_req=mem_op. If no ack: go to WAIT and load the timeout counter with ACK_TIMEOUT-1.
  - WAIT: req held with address, data and be stable. Counter decrements each cycle.
  - WAIT -> IDLE on ack. On ack the instruction retires normally.
  - If the counter reaches 0 without ack: go to IDLE, pulse o_bus_err, retire with regwrite 0, deassert req.
- o_stall = mem_op & ~i_dmem_ack & ~timeout_expire (combinational).
- o_ma_op = memtoreg==10 ? pcplus4 : exe_calc. Load-use hazards are the hazard unit's responsibility.
- WB register updates every cycle.
  - When stalled: o_cu_regwrite<=0 (bubble).
  - Otherwise: o_cu_regwrite <= ma_valid & regwrite & ~misaligned & ~buserr, o_rdest <= rdest, o_wb_data <= mux(memtoreg) of exe_calc, formatted load, pcplus4.
- Stores with regwrite=1 are legal; the written value is the mux result.

## Timing
- Reset values:
  - FSM=IDLE, ma_valid=0, counter=0.
  - o_dmem_req, o_dmem_we, o_stall, o_cu_regwrite, o_misaligned, o_bus_err = 0.
  - o_wb_data=0, o_rdest=0, o_dmem_be=0.
- Reset during WAIT drops req asynchronously, with no retirement.
- Non-memory instruction: EX output -> MA reg (edge 1) -> WB outputs (edge 2). Latency 2 edges, no stall.
- Zero-wait memory (ack in the request cycle): same latency, o_stall never asserted.
- N-wait memory: o_stall high N cycles, and N bubbles are presented to WB.
- A new request may start in the cycle after an ack. Back-to-back loads with zero wait give one access per cycle.
- Timeout: req asserted exactly ACK_TIMEOUT cycles. o_bus_err pulses on the edge after the last one.
- Ack arriving on the same cycle as timeout expiry counts as ack; no error.

## Structure
- multicore_pkg holds t_ldop (LB, LH, LW, LBU, LHU), t_sop (SB, SH, SW), a t_ma_state enum, and the memtoreg constants MTR_ALU/MTR_MEM/MTR_PC.
- Sub-module load_store_align (combinational): the lane steering, be generation, load extension and misalignment check. The FSM and registers stay in memory_access_unit.

## Test plan
- ALU op, calc=0x1234, memtoreg=00, regwrite=1, rdest=5 -> two edges later o_wb_data=0x1234, o_rdest=5, o_cu_regwrite=1, no req.
- SB addr=0x103, wdata=0xAB, ack zero-wait -> req=1, we=1, addr=0x100, be=1000, wdata=0xABABABAB, stall=0.
- LB addr=0x102, rdata=0x0080_0000, 3-cycle ack delay -> o_stall high 3 cycles, o_wb_data=0xFFFFFF80. Repeat with LBU -> 0x00000080.
- SW addr=0x102 -> no req, o_misaligned pulse, regwrite 0. The next instruction proceeds unstalled.
- ACK_TIMEOUT=4, load never acked -> req high exactly 4 cycles, o_bus_err pulse, regwrite 0, stall released.
- Assert reset while in WAIT -> req and stall drop immediately; after release, FSM is IDLE and outputs are at reset values.
